// File: rtl/occ_pkg.sv
// Shared types and limits for the parking occupancy counter.
package occ_pkg;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        AVAILABLE = 2'd1,
        FULL      = 2'd2
    } occ_status_t;

    localparam int MAX_LANES = 8;
    // Wide enough to hold a per-cycle event count across all lanes.
    localparam int EVENT_W = $clog2(MAX_LANES + 1);

endpackage

// File: rtl/edge_detect.sv
// Per-bit rising-edge detector; history resets to ones so a level already
// high when reset releases does not produce an event.
module edge_detect #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] history;

    always_ff @(posedge clock) begin
        if (reset) begin
            history <= '1;
        end else begin
            history <= level;
        end
    end

    assign rise = level & ~history;

endmodule

// File: rtl/parking_occupancy.sv
// Lot occupancy counter: counts entry/exit sensor edges over all lanes,
// clamps to 0..CAPACITY with sticky error flags, and tracks lot status.
module parking_occupancy
    import occ_pkg::*;
#(
    parameter int  LANES     = 2,
    parameter int  CAPACITY  = 25,
    parameter int  NEAR_FULL = CAPACITY - 2,
    localparam int COUNT_W   = $clog2(CAPACITY + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LANES-1:0]   enter,
    input  logic [LANES-1:0]   exit,
    input  logic               load,
    input  logic [COUNT_W-1:0] load_value,
    input  logic               clear_err,
    output logic [COUNT_W-1:0] count,
    output logic [COUNT_W-1:0] free,
    output occ_status_t        status,
    output logic               full,
    output logic               empty,
    output logic               near_full,
    output logic               overflow_err,
    output logic               underflow_err
);

    localparam int                  SUM_W = COUNT_W + 4;
    localparam logic [COUNT_W-1:0]  CAP_C = COUNT_W'(CAPACITY);
    localparam logic [COUNT_W-1:0]  NF_C  = COUNT_W'(NEAR_FULL);
    localparam logic signed [SUM_W-1:0] CAP_S = SUM_W'(CAPACITY);

    logic [LANES-1:0]        enter_rise;
    logic [LANES-1:0]        exit_rise;
    logic [EVENT_W-1:0]      enter_cnt;
    logic [EVENT_W-1:0]      exit_cnt;
    logic signed [SUM_W-1:0] sum;
    logic [COUNT_W-1:0]      count_next;
    occ_status_t             status_next;
    logic                    set_ovf;
    logic                    set_unf;

    edge_detect #(.WIDTH(LANES)) u_enter_edge (
        .clock (clock),
        .reset (reset),
        .level (enter),
        .rise  (enter_rise)
    );

    edge_detect #(.WIDTH(LANES)) u_exit_edge (
        .clock (clock),
        .reset (reset),
        .level (exit),
        .rise  (exit_rise)
    );

    always_comb begin
        enter_cnt = '0;
        exit_cnt  = '0;
        for (int i = 0; i < LANES; i++) begin
            enter_cnt = enter_cnt + EVENT_W'(enter_rise[i]);
            exit_cnt  = exit_cnt + EVENT_W'(exit_rise[i]);
        end
        sum = $signed({{(SUM_W-COUNT_W){1'b0}}, count})
            + $signed({{(SUM_W-EVENT_W){1'b0}}, enter_cnt})
            - $signed({{(SUM_W-EVENT_W){1'b0}}, exit_cnt});

        count_next = count;
        set_ovf    = 1'b0;
        set_unf    = 1'b0;
        // A load discards this cycle's events; edge history still advances.
        if (load) begin
            if (load_value > CAP_C) begin
                count_next = CAP_C;
                set_ovf    = 1'b1;
            end else begin
                count_next = load_value;
            end
        end else if (sum > CAP_S) begin
            count_next = CAP_C;
            set_ovf    = 1'b1;
        end else if (sum[SUM_W-1]) begin
            count_next = '0;
            set_unf    = 1'b1;
        end else begin
            count_next = sum[COUNT_W-1:0];
        end

        if (count_next == '0) begin
            status_next = EMPTY;
        end else if (count_next == CAP_C) begin
            status_next = FULL;
        end else begin
            status_next = AVAILABLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count         <= '0;
            status        <= EMPTY;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            count         <= count_next;
            status        <= status_next;
            // A new error in the same cycle as clear_err keeps the flag set.
            overflow_err  <= set_ovf | (overflow_err & ~clear_err);
            underflow_err <= set_unf | (underflow_err & ~clear_err);
        end
    end

    assign free      = CAP_C - count;
    assign full      = (count == CAP_C);
    assign empty     = (count == '0);
    assign near_full = (count >= NF_C);

endmodule

// File: tb/tb_parking_occupancy.sv
// Directed bench for parking_occupancy: the driver pushes hand-computed expected
// snapshots, a negedge monitor pops and compares them against the outputs.
module tb_parking_occupancy;
    import occ_pkg::*;

    localparam int LANES    = 2;
    localparam int CAPACITY = 25;
    localparam int NF       = 23;
    localparam int COUNT_W  = 5;
    localparam int SNAP_W   = 2 * COUNT_W + 2 + 5;

    logic               clock;
    logic               reset;
    logic [LANES-1:0]   enter;
    logic [LANES-1:0]   exit;
    logic               load;
    logic [COUNT_W-1:0] load_value;
    logic               clear_err;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] free;
    occ_status_t        status;
    logic               full;
    logic               empty;
    logic               near_full;
    logic               overflow_err;
    logic               underflow_err;

    logic [SNAP_W-1:0] exp_q[$];
    string             name_q[$];
    int                checks;
    int                errors;

    parking_occupancy #(
        .LANES     (LANES),
        .CAPACITY  (CAPACITY),
        .NEAR_FULL (NF)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enter         (enter),
        .exit          (exit),
        .load          (load),
        .load_value    (load_value),
        .clear_err     (clear_err),
        .count         (count),
        .free          (free),
        .status        (status),
        .full          (full),
        .empty         (empty),
        .near_full     (near_full),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Apply one cycle of inputs; returns 1 time unit after the capturing posedge.
    task automatic cycle(input logic rst, input logic [1:0] en, input logic [1:0] ex,
                         input logic ld, input int lv, input logic clr);
        reset      = rst;
        enter      = en;
        exit       = ex;
        load       = ld;
        load_value = COUNT_W'(lv);
        clear_err  = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input string name, input int c, input occ_status_t st,
                            input logic ovf, input logic unf);
        logic [COUNT_W-1:0] c_v;
        logic [COUNT_W-1:0] f_v;
        c_v = COUNT_W'(c);
        f_v = COUNT_W'(CAPACITY - c);
        exp_q.push_back({c_v, f_v, st, (c == CAPACITY), (c == 0), (c >= NF), ovf, unf});
        name_q.push_back(name);
    endtask

    // Scoreboard monitor
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            logic [SNAP_W-1:0] exp_v;
            logic [SNAP_W-1:0] got_v;
            string             nm;
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            got_v = {count, free, status, full, empty, near_full, overflow_err, underflow_err};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL %s: got cnt=%0d free=%0d st=%0d f/e/nf=%b%b%b ovf=%b unf=%b, exp cnt=%0d free=%0d st=%0d f/e/nf=%b%b%b ovf=%b unf=%b",
                         nm, got_v[16:12], got_v[11:7], got_v[6:5], got_v[4], got_v[3], got_v[2],
                         got_v[1], got_v[0], exp_v[16:12], exp_v[11:7], exp_v[6:5], exp_v[4],
                         exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1; enter = '0; exit = '0; load = 1'b0; load_value = '0; clear_err = 1'b0;

        // Reset with both entry sensors high; no event after release
        cycle(1, 2'b11, 2'b00, 0, 0, 0);
        cycle(1, 2'b11, 2'b00, 0, 0, 0);
        push_exp("reset", 0, EMPTY, 0, 0);
        cycle(0, 2'b11, 2'b00, 0, 0, 0);
        cycle(0, 2'b11, 2'b00, 0, 0, 0);
        cycle(0, 2'b11, 2'b00, 0, 0, 0);
        push_exp("held_high", 0, EMPTY, 0, 0);
        cycle(0, 2'b00, 2'b00, 0, 0, 0);
        push_exp("dropped", 0, EMPTY, 0, 0);
        cycle(0, 2'b11, 2'b00, 0, 0, 0);
        push_exp("rerise", 2, AVAILABLE, 0, 0);

        // Single lane: 5 entries then 3 exits
        cycle(0, 2'b00, 2'b00, 1, 0, 0);
        push_exp("load0", 0, EMPTY, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 2'b01, 2'b00, 0, 0, 0);
            cycle(0, 2'b00, 2'b00, 0, 0, 0);
        end
        push_exp("enter5", 5, AVAILABLE, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 2'b00, 2'b01, 0, 0, 0);
            cycle(0, 2'b00, 2'b00, 0, 0, 0);
        end
        push_exp("exit3", 2, AVAILABLE, 0, 0);

        // Simultaneous enter/exit cancel; two entries in one cycle
        cycle(0, 2'b00, 2'b00, 1, 10, 0);
        push_exp("load10", 10, AVAILABLE, 0, 0);
        cycle(0, 2'b01, 2'b10, 0, 0, 0);
        push_exp("cancel", 10, AVAILABLE, 0, 0);
        cycle(0, 2'b00, 2'b00, 0, 0, 0);
        cycle(0, 2'b11, 2'b00, 0, 0, 0);
        push_exp("dual_enter", 12, AVAILABLE, 0, 0);

        // Overflow clamp and clear
        cycle(0, 2'b00, 2'b00, 1, 24, 0);
        push_exp("load24", 24, AVAILABLE, 0, 0);
        cycle(0, 2'b11, 2'b00, 0, 0, 0);
        push_exp("overflow", 25, FULL, 1, 0);
        cycle(0, 2'b00, 2'b00, 0, 0, 1);
        push_exp("clear_ovf", 25, FULL, 0, 0);

        // Underflow clamp, clear, and clear losing to a new underflow
        cycle(0, 2'b00, 2'b00, 1, 1, 0);
        push_exp("load1", 1, AVAILABLE, 0, 0);
        cycle(0, 2'b00, 2'b11, 0, 0, 0);
        push_exp("underflow", 0, EMPTY, 0, 1);
        cycle(0, 2'b00, 2'b00, 0, 0, 1);
        push_exp("clear_unf", 0, EMPTY, 0, 0);
        cycle(0, 2'b00, 2'b00, 1, 1, 0);
        push_exp("load1_again", 1, AVAILABLE, 0, 0);
        cycle(0, 2'b00, 2'b11, 0, 0, 1);
        push_exp("clear_vs_unf", 0, EMPTY, 0, 1);

        // Oversized load with a coincident entry event
        cycle(0, 2'b01, 2'b00, 1, 30, 0);
        push_exp("load30", 25, FULL, 1, 1);
        cycle(0, 2'b01, 2'b00, 0, 0, 0);
        push_exp("hist_on_load", 25, FULL, 1, 1);
        cycle(0, 2'b00, 2'b01, 0, 0, 0);
        push_exp("exit_after_load", 24, AVAILABLE, 1, 1);

        // Reset mid-operation beats load/clear/events
        cycle(1, 2'b11, 2'b00, 1, 5, 1);
        push_exp("reset_mid", 0, EMPTY, 0, 0);
        cycle(0, 2'b11, 2'b00, 0, 0, 0);
        push_exp("post_reset_held", 0, EMPTY, 0, 0);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clock);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected snapshots left unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parking_occupancy.md
PARKING_OCCUPANCY -- requirements
Module: parking_occupancy

Interface
REQ-001 Parameter: LANES, default 2, number of independent entry/exit sensor lanes (1..8).
REQ-002 Parameter: CAPACITY, default 25, maximum legal occupancy (1..255).
REQ-003 Parameter: NEAR_FULL, default CAPACITY-2, threshold for near_full flag.
REQ-004 Derived constant: COUNT_W = clog2(CAPACITY+1); not overridable.
REQ-005 Reset and clock: reset, synchronous, active-high; clock clock.
REQ-006 clock  input  1  rising-edge clock for all state.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 enter  input  LANES  per-lane entry sensor level, synchronous to clock.
REQ-009 exit  input  LANES  per-lane exit sensor level, synchronous to clock.
REQ-010 load  input  1  overwrite occupancy with load_value this cycle.
REQ-011 load_value  input  COUNT_W  occupancy value to load.
REQ-012 clear_err  input  1  clears sticky error flags.
REQ-013 count  output  COUNT_W  current occupancy.
REQ-014 free  output  COUNT_W  CAPACITY - count.
REQ-015 status  output  2  lot state: EMPTY, AVAILABLE, FULL.
REQ-016 full / empty / near_full  output  1 each  count==CAPACITY / count==0 / count>=NEAR_FULL.
REQ-017 overflow_err / underflow_err  output  1 each  sticky: an update was clamped high / low.

Function
REQ-018 Event = rising edge of enter[i] or exit[i]: level 1 at current posedge, 0 at previous posedge; levels held high produce one event only.
REQ-019 Per cycle E = number of enter events, X = number of exit events, all lanes; simultaneous events on any lanes all counted.
REQ-020 Net update computed signed, width COUNT_W+4: next = count + E - X.
REQ-021 next > CAPACITY: count <= CAPACITY, overflow_err <= 1.
REQ-022 next < 0: count <= 0, underflow_err <= 1.
REQ-023 Otherwise count <= next; E==X gives no change and no error.
REQ-024 Latency: count reflects an event at the posedge that detects it; event level rises before posedge k -> new count visible after posedge k.
REQ-025 load has priority over events: count <= min(load_value, CAPACITY); events that cycle discarded; load_value > CAPACITY sets overflow_err.
REQ-026 Edge history registers update every non-reset cycle, including load cycles.
REQ-027 clear_err clears both sticky flags; an error arising in same cycle wins (flag stays 1).
REQ-028 free, full, empty, near_full combinational from registered count.
REQ-029 status FSM registered, mirrors next count: EMPTY (0), AVAILABLE (1..CAPACITY-1), FULL (CAPACITY); any state to any state in one cycle permitted (multi-lane jumps).

Reset
REQ-030 On reset: count=0, status=EMPTY, overflow_err=0, underflow_err=0; free=CAPACITY, empty=1, full=0, near_full=0.
REQ-031 Edge history registers reset to all ones: sensors high during/after reset produce no event until they fall and rise again.
REQ-032 Reset mid-operation overrides load, clear_err and events in that cycle.

Structure
REQ-033 Shared package occ_pkg: status enum type (EMPTY, AVAILABLE, FULL) and lane-count limit constant.
REQ-034 One sub-module, edge_detect, parametrised by width, with reset-to-ones history; instantiated twice (enter, exit).
REQ-035 Popcount and clamp logic inline in parking_occupancy.

Verification (LANES=2, CAPACITY=25, NEAR_FULL=23)
REQ-036 Reset with enter=2'b11 held -> count=0, empty=1; hold 3 cycles -> count stays 0; drop and re-raise both -> count=2.
REQ-037 Single lane 5 entry pulses then 3 exit pulses -> count 5 then 2, status AVAILABLE, no errors.
REQ-038 Same-cycle enter[0] and exit[1] rise with count=10 -> count stays 10; enter both lanes -> 12.
REQ-039 load 24, then both enter lanes rise -> count=25, full=1, overflow_err=1, status FULL; clear_err -> overflow_err=0.
REQ-040 count=1, both exit lanes rise -> count=0, underflow_err=1, status EMPTY; clear_err same cycle as new underflow -> flag stays 1.
REQ-041 load 30 with an enter event same cycle -> count=25, overflow_err=1, event ignored; near_full=1, free=0.
